brcmp_serial: RTL and testbench

- Byte-serial branch comparator for the RISC-V branch path: the area-lean multi-cycle counterpart of the single-cycle combinational compare tree.
- The combinational tree resolves MSB-dominant in one pass; this block walks the operands in the other direction, LSB byte first, one byte per cycle.
- It holds a running relation that each more-significant byte overrides.
- It takes two WIDTH-bit operands plus a branch funct3 over a valid/ready handshake and returns equal/greater/less flags and a branch-taken decision.

---
 rtl/brcmp_pkg.sv | 27 ++
 rtl/brcmp_serial_cmp_8.sv | 12 +
 rtl/brcmp_serial.sv | 129 ++++++++++++
 tb/tb_brcmp_serial.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/brcmp_pkg.sv
// Shared types and branch decode for the byte-serial branch comparator.
package brcmp_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} brcmp_state_e;
  typedef enum logic [1:0] {REL_EQ, REL_GT, REL_LT} brcmp_rel_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic branch_taken(input logic [2:0] f3, input brcmp_rel_e rel);
    logic taken;
    taken = 1'b0;
    case (f3)
      F3_BEQ:           taken = (rel == REL_EQ);
      F3_BNE:           taken = (rel != REL_EQ);
      F3_BLT, F3_BLTU:  taken = (rel == REL_LT);
      F3_BGE, F3_BGEU:  taken = (rel != REL_LT);
      default:          taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/brcmp_serial_cmp_8.sv
// Unsigned 8-bit magnitude compare used for one byte step of the serial walk.
module cmp_8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic       gt_o,
  output logic       lt_o
);

  assign gt_o = (a_i > b_i);
  assign lt_o = (a_i < b_i);

endmodule

// File: rtl/brcmp_serial.sv
// Byte-serial branch comparator: walks operands LSB byte first, each
// more-significant differing byte overrides the running relation.
module brcmp_serial
  import brcmp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       funct3_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             equal_o,
  output logic             alarger_o,
  output logic             blarger_o,
  output logic             taken_o,
  output logic             illegal_o
);

  localparam int NBYTES = WIDTH / 8;
  localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  brcmp_state_e     state_q, state_d;
  brcmp_rel_e       rel_q, rel_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       f3_q, f3_d;

  logic       last_byte;
  logic       sign_swap;
  logic [7:0] byte_a, byte_b;
  logic       byte_gt, byte_lt;

  // Operands shift right each RUN cycle, so the current byte is always [7:0].
  assign last_byte = (idx_q == IDXW'(NBYTES - 1));
  assign sign_swap = last_byte & ~f3_q[1];
  assign byte_a    = {a_q[7] ^ sign_swap, a_q[6:0]};
  assign byte_b    = {b_q[7] ^ sign_swap, b_q[6:0]};

  cmp_8 u_cmp_8 (
    .a_i  (byte_a),
    .b_i  (byte_b),
    .gt_o (byte_gt),
    .lt_o (byte_lt)
  );

  always_comb begin
    state_d = state_q;
    rel_d   = rel_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    f3_d    = f3_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          f3_d    = funct3_i;
          rel_d   = REL_EQ;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (byte_gt) rel_d = REL_GT;
        else if (byte_lt) rel_d = REL_LT;
        a_d = a_q >> 8;
        b_d = b_q >> 8;
        if (last_byte) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rel_q   <= REL_EQ;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      f3_q    <= '0;
    end else begin
      state_q <= state_d;
      rel_q   <= rel_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f3_q    <= f3_d;
    end
  end

  // Result flags are only exposed while a result is held in DONE.
  always_comb begin
    ready_o   = 1'b0;
    valid_o   = 1'b0;
    equal_o   = 1'b0;
    alarger_o = 1'b0;
    blarger_o = 1'b0;
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (state_q)
      IDLE: ready_o = 1'b1;
      DONE: begin
        valid_o   = 1'b1;
        equal_o   = (rel_q == REL_EQ);
        alarger_o = (rel_q == REL_GT);
        blarger_o = (rel_q == REL_LT);
        taken_o   = branch_taken(f3_q, rel_q);
        illegal_o = (f3_q[2:1] == 2'b01);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_brcmp_serial.sv
// Self-checking bench for brcmp_serial: directed table, random vs. model, corner sequences.
module tb_brcmp_serial;

  localparam int WIDTH  = 32;
  localparam int NBYTES = WIDTH / 8;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i, b_i;
  logic [2:0]       funct3_i;
  logic             valid_o;
  logic             ready_i;
  logic             equal_o, alarger_o, blarger_o, taken_o, illegal_o;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  brcmp_serial #(.WIDTH(WIDTH)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .a_i       (a_i),
    .b_i       (b_i),
    .funct3_i  (funct3_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .equal_o   (equal_o),
    .alarger_o (alarger_o),
    .blarger_o (blarger_o),
    .taken_o   (taken_o),
    .illegal_o (illegal_o)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic [4:0]  exp; // {equal, alarger, blarger, taken, illegal}
  } vec_t;

  vec_t tbl[9];

  function automatic logic [4:0] flags_now();
    return {equal_o, alarger_o, blarger_o, taken_o, illegal_o};
  endfunction

  // Reference: whole-word compare with the signedness picked by funct3[1].
  function automatic logic [4:0] model(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] f3);
    logic eq, gt, lt, tk, il;
    eq = (a == b);
    if (!f3[1]) gt = ($signed(a) > $signed(b));
    else        gt = (a > b);
    lt = !eq && !gt;
    il = (f3 == 3'b010) || (f3 == 3'b011);
    case (f3)
      3'b000:         tk = eq;
      3'b001:         tk = !eq;
      3'b100, 3'b110: tk = lt;
      3'b101, 3'b111: tk = !lt;
      default:        tk = 1'b0;
    endcase
    return {eq, gt, lt, tk, il};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1 with the block idle; returns cycles from accept to valid_o.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                       input bit junk, output int lat);
    chk("ready_before_accept", 32'(ready_o), 32'd1);
    valid_i  = 1'b1;
    a_i      = a;
    b_i      = b;
    funct3_i = f3;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (junk) begin
        valid_i  = 1'($urandom_range(0, 1));
        a_i      = $urandom;
        b_i      = $urandom;
        funct3_i = 3'($urandom);
      end
      lat = k;
      if (valid_o) break;
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
  endtask

  task automatic consume();
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
  endtask

  int          lat;
  logic [4:0]  held;
  logic [31:0] ra, rb;
  logic [2:0]  rf;

  initial begin
    tbl[0] = '{32'h12345678, 32'h12345678, 3'b000, 5'b10010};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 3'b100, 5'b00110};
    tbl[2] = '{32'hFFFFFFFF, 32'h00000001, 3'b110, 5'b01000};
    tbl[3] = '{32'h01000000, 32'h00FFFFFF, 3'b111, 5'b01010};
    tbl[4] = '{32'h00000005, 32'h00000003, 3'b010, 5'b01001};
    tbl[5] = '{32'h80000000, 32'h7FFFFFFF, 3'b101, 5'b00100};
    tbl[6] = '{32'h00000001, 32'h00000002, 3'b001, 5'b00110};
    tbl[7] = '{32'h00000100, 32'h000000FF, 3'b011, 5'b01001};
    tbl[8] = '{32'hFFFFFF00, 32'hFFFFFF01, 3'b111, 5'b00100};

    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    a_i = '0; b_i = '0; funct3_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    chk("reset_ready", 32'(ready_o), 32'd1);
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_flags", 32'(flags_now()), 32'd0);

    for (int i = 0; i < 9; i++) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].f3, 1'b0, lat);
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(NBYTES + 1));
      chk($sformatf("tbl%0d_flags", i), 32'(flags_now()), 32'(tbl[i].exp));
      $display("vec tbl%0d a=%h b=%h f3=%b flags=%b", i, tbl[i].a, tbl[i].b, tbl[i].f3, flags_now());
      consume();
      chk($sformatf("tbl%0d_idle", i), 32'({ready_o, valid_o}), 32'b10);
    end

    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rb = (i % 4 == 0) ? ra : ((i % 4 == 1) ? (ra ^ (32'h1 << $urandom_range(0, 31))) : $urandom);
      rf = 3'($urandom);
      issue(ra, rb, rf, 1'b1, lat);
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(NBYTES + 1));
      chk($sformatf("rnd%0d_flags", i), 32'(flags_now()), 32'(model(ra, rb, rf)));
      $display("vec rnd%0d a=%h b=%h f3=%b flags=%b", i, ra, rb, rf, flags_now());
      consume();
    end

    // Backpressure: result must hold while ready_i is low, then re-accept in the first idle cycle.
    issue(32'h00000007, 32'h00000009, 3'b110, 1'b0, lat);
    held = flags_now();
    chk("bp_flags", 32'(held), 32'(model(32'h7, 32'h9, 3'b110)));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i); #1;
      chk($sformatf("bp_hold%0d", k), 32'({valid_o, ready_o, flags_now()}), 32'({2'b10, held}));
    end
    consume();
    chk("bp_release", 32'({ready_o, valid_o}), 32'b10);
    issue(32'hAAAA0000, 32'hAAAA0000, 3'b001, 1'b0, lat);
    chk("bp_next_latency", 32'(lat), 32'(NBYTES + 1));
    chk("bp_next_flags", 32'(flags_now()), 32'(model(32'hAAAA0000, 32'hAAAA0000, 3'b001)));
    $display("vec backpressure flags=%b", flags_now());
    consume();

    // Reset mid-RUN aborts the operation.
    valid_i = 1'b1; a_i = 32'h5; b_i = 32'h3; funct3_i = 3'b000;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    chk("rst_run_state", 32'({ready_o, valid_o}), 32'b10);
    chk("rst_run_flags", 32'(flags_now()), 32'd0);
    for (int k = 0; k < NBYTES + 2; k++) begin
      @(posedge clk_i); #1;
      chk($sformatf("rst_no_result%0d", k), 32'(valid_o), 32'd0);
    end
    issue(32'h80000001, 32'h00000001, 3'b101, 1'b0, lat);
    chk("rst_after_latency", 32'(lat), 32'(NBYTES + 1));
    chk("rst_after_flags", 32'(flags_now()), 32'(model(32'h80000001, 32'h1, 3'b101)));
    $display("vec reset_mid_run flags=%b", flags_now());

    // Reset while holding a result in DONE.
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    chk("rst_done_state", 32'({ready_o, valid_o, flags_now()}), 32'({2'b10, 5'b0}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
